// File: rtl/instruction_queue.sv
// instruction_queue
//   Circular FIFO of instruction entries. Each entry is emitted downstream as
//   1..2^LOG_SUPERSCALAR_WIDTH copies. Per-copy cache and main-memory
//   addresses are formed by repeated addition of the stored strides.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | output registers empty, pop_valid=0, waiting for an entry
//   EMIT  | head entry's current copy is presented, pop_valid=1
//
// Ports
//   clk                   : single clock, rising edge
//   reset                 : asynchronous active-low reset
//   push_we               : push request
//   push_instr_type/instr : instruction type and raw word
//   push_*_addr           : base addresses and per-copy strides (18 bit)
//   push_copy_count       : copies to emit (0 -> 1, >max -> max)
//   full, count, overflow : occupancy status; overflow is sticky
//   pop_valid/pop_ready   : downstream handshake
//   pop_*                 : registered copy data and copy index

module instruction_queue #(
  parameter int LOG_DEPTH             = 4,
  parameter int LOG_SUPERSCALAR_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_we,
  input  logic [1:0]                       push_instr_type,
  input  logic [15:0]                      push_instr,
  input  logic [17:0]                      push_cache_addr,
  input  logic [17:0]                      push_main_mem_addr,
  input  logic [17:0]                      push_d_cache_addr,
  input  logic [17:0]                      push_d_main_mem_addr,
  input  logic [LOG_SUPERSCALAR_WIDTH:0]   push_copy_count,
  output logic                             full,
  output logic [LOG_DEPTH:0]               count,
  output logic                             overflow,
  output logic                             pop_valid,
  input  logic                             pop_ready,
  output logic [1:0]                       pop_instr_type,
  output logic [15:0]                      pop_instr,
  output logic [17:0]                      pop_cache_addr,
  output logic [17:0]                      pop_main_mem_addr,
  output logic [LOG_SUPERSCALAR_WIDTH-1:0] pop_copy_index
);

  localparam int LSW   = LOG_SUPERSCALAR_WIDTH;
  localparam int DEPTH = 1 << LOG_DEPTH;

  localparam logic [LOG_DEPTH:0]   CNT_FULL   = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE    = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE    = LOG_DEPTH'(1);
  localparam logic [LSW:0]         MAX_COPIES = (LSW+1)'(1 << LSW);
  localparam logic [LSW:0]         COPY_ONE   = (LSW+1)'(1);
  localparam logic [LSW-1:0]       IDX_ONE    = LSW'(1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  // last_index is stored as (clamped copy count - 1) so the end-of-entry
  // test is a plain equality against the running copy index.
  typedef struct packed {
    logic [1:0]  instr_type;
    logic [15:0] instr;
    logic [17:0] cache_addr;
    logic [17:0] main_mem_addr;
    logic [17:0] d_cache_addr;
    logic [17:0] d_main_mem_addr;
    logic [LSW:0] last_index;
  } entry_t;

  entry_t               mem [DEPTH];
  entry_t               push_entry;
  entry_t               load_entry;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH-1:0] wr_ptr;
  state_t               state;
  logic [17:0]          cur_d_cache;
  logic [17:0]          cur_d_main;
  logic [LSW:0]         cur_last;

  logic push_accept;
  logic transfer;
  logic last_copy;
  logic retire;
  logic more_entries;
  logic do_load;

  // Push-side sanitising of the copy count.
  always_comb begin
    push_entry.instr_type      = push_instr_type;
    push_entry.instr           = push_instr;
    push_entry.cache_addr      = push_cache_addr;
    push_entry.main_mem_addr   = push_main_mem_addr;
    push_entry.d_cache_addr    = push_d_cache_addr;
    push_entry.d_main_mem_addr = push_d_main_mem_addr;
    if (push_copy_count == '0)
      push_entry.last_index = '0;
    else if (push_copy_count > MAX_COPIES)
      push_entry.last_index = MAX_COPIES - COPY_ONE;
    else
      push_entry.last_index = push_copy_count - COPY_ONE;
  end

  assign full         = (count == CNT_FULL);
  assign push_accept  = push_we && !full;
  assign transfer     = pop_valid && pop_ready;
  assign last_copy    = ({1'b0, pop_copy_index} == cur_last);
  assign retire       = transfer && last_copy;
  // count still includes the entry being retired, so >=2 means a successor
  // is already stored. A push on this same edge is not yet visible.
  assign more_entries = (count > CNT_ONE);
  assign do_load      = ((state == IDLE) && (count != '0)) || (retire && more_entries);

  // In IDLE the head is the entry to load; in EMIT the head is still the
  // entry being retired, so its successor is loaded instead.
  assign load_entry = (state == IDLE) ? mem[rd_ptr] : mem[rd_ptr + PTR_ONE];

  // Entry storage carries no reset: reset discards entries via the pointers.
  always_ff @(posedge clk) begin
    if (push_accept)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_accept)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (retire)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_accept, retire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push_we && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      pop_valid         <= 1'b0;
      pop_instr_type    <= '0;
      pop_instr         <= '0;
      pop_cache_addr    <= '0;
      pop_main_mem_addr <= '0;
      pop_copy_index    <= '0;
      cur_d_cache       <= '0;
      cur_d_main        <= '0;
      cur_last          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= EMIT;
            pop_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (retire && !more_entries) begin
            state     <= IDLE;
            pop_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          pop_valid <= 1'b0;
        end
      endcase

      if (do_load) begin
        pop_instr_type    <= load_entry.instr_type;
        pop_instr         <= load_entry.instr;
        pop_cache_addr    <= load_entry.cache_addr;
        pop_main_mem_addr <= load_entry.main_mem_addr;
        pop_copy_index    <= '0;
        cur_d_cache       <= load_entry.d_cache_addr;
        cur_d_main        <= load_entry.d_main_mem_addr;
        cur_last          <= load_entry.last_index;
      end else if (transfer && !last_copy) begin
        // Next copy's addresses by accumulation; wraps modulo 2^18.
        pop_cache_addr    <= pop_cache_addr + cur_d_cache;
        pop_main_mem_addr <= pop_main_mem_addr + cur_d_main;
        pop_copy_index    <= pop_copy_index + IDX_ONE;
      end
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue
//   Drives instruction_queue with directed scenarios and random traffic and
//   compares every cycle against a queue-based reference model. Copy
//   addresses in the model are computed as base + index * stride.

module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_we;
  logic [1:0]  push_instr_type;
  logic [15:0] push_instr;
  logic [17:0] push_cache_addr;
  logic [17:0] push_main_mem_addr;
  logic [17:0] push_d_cache_addr;
  logic [17:0] push_d_main_mem_addr;
  logic [3:0]  push_copy_count;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic        pop_valid;
  logic        pop_ready;
  logic [1:0]  pop_instr_type;
  logic [15:0] pop_instr;
  logic [17:0] pop_cache_addr;
  logic [17:0] pop_main_mem_addr;
  logic [2:0]  pop_copy_index;

  always #5 clk = ~clk;

  instruction_queue #(.LOG_DEPTH(4), .LOG_SUPERSCALAR_WIDTH(3)) dut (
    .clk                  (clk),
    .reset                (reset),
    .push_we              (push_we),
    .push_instr_type      (push_instr_type),
    .push_instr           (push_instr),
    .push_cache_addr      (push_cache_addr),
    .push_main_mem_addr   (push_main_mem_addr),
    .push_d_cache_addr    (push_d_cache_addr),
    .push_d_main_mem_addr (push_d_main_mem_addr),
    .push_copy_count      (push_copy_count),
    .full                 (full),
    .count                (count),
    .overflow             (overflow),
    .pop_valid            (pop_valid),
    .pop_ready            (pop_ready),
    .pop_instr_type       (pop_instr_type),
    .pop_instr            (pop_instr),
    .pop_cache_addr       (pop_cache_addr),
    .pop_main_mem_addr    (pop_main_mem_addr),
    .pop_copy_index       (pop_copy_index)
  );

  typedef struct {
    int ty;
    int instr;
    int cache;
    int main;
    int dca;
    int dma;
    int copies;
  } ent_t;

  ent_t q[$];
  bit   m_valid;
  int   m_copy;
  bit   m_ovf;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_copies(input int c);
    if (c == 0) return 1;
    if (c > 8) return 8;
    return c;
  endfunction

  // One clock edge of the reference behaviour, using the inputs being driven.
  task automatic model_step();
    int  pre;
    bit  is_full;
    ent_t e;
    pre     = q.size();
    is_full = (pre == 16);
    if (push_we && is_full) m_ovf = 1'b1;
    if (m_valid && pop_ready) begin
      if (m_copy < q[0].copies - 1) begin
        m_copy++;
      end else begin
        q.delete(0);
        if (pre >= 2) m_copy = 0;
        else m_valid = 1'b0;
      end
    end else if (!m_valid && pre > 0) begin
      m_valid = 1'b1;
      m_copy  = 0;
    end
    if (push_we && !is_full) begin
      e.ty     = int'(push_instr_type);
      e.instr  = int'(push_instr);
      e.cache  = int'(push_cache_addr);
      e.main   = int'(push_main_mem_addr);
      e.dca    = int'(push_d_cache_addr);
      e.dma    = int'(push_d_main_mem_addr);
      e.copies = clamp_copies(int'(push_copy_count));
      q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    ent_t e;
    check("pop_valid", pop_valid, m_valid);
    check("count", count, q.size());
    check("full", full, q.size() == 16);
    check("overflow", overflow, m_ovf);
    if (m_valid) begin
      e = q[0];
      check("pop_type", pop_instr_type, e.ty);
      check("pop_instr", pop_instr, e.instr);
      check("pop_cache", pop_cache_addr, (e.cache + m_copy * e.dca) & 32'h3FFFF);
      check("pop_main", pop_main_mem_addr, (e.main + m_copy * e.dma) & 32'h3FFFF);
      check("pop_index", pop_copy_index, m_copy);
    end
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input bit we, input int ty, input int ins, input int ca, input int dca,
                       input int ma, input int dma, input int cc, input bit rdy);
    push_we              = we;
    push_instr_type      = 2'(ty);
    push_instr           = 16'(ins);
    push_cache_addr      = 18'(ca);
    push_d_cache_addr    = 18'(dca);
    push_main_mem_addr   = 18'(ma);
    push_d_main_mem_addr = 18'(dma);
    push_copy_count      = 4'(cc);
    pop_ready            = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 0, 0, 0, 1, rdy);
  endtask

  // Asserted between edges so the asynchronous clear is observed directly.
  task automatic do_reset();
    push_we   = 1'b0;
    pop_ready = 1'b0;
    reset     = 1'b0;
    #1;
    q.delete();
    m_valid = 1'b0;
    m_copy  = 0;
    m_ovf   = 1'b0;
    check_outputs();
    check("rst_index", pop_copy_index, 0);
    check("rst_cache", pop_cache_addr, 0);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  int seen[$];

  initial begin
    reset = 1'b0;
    push_we = 1'b0; push_instr_type = '0; push_instr = '0;
    push_cache_addr = '0; push_main_mem_addr = '0;
    push_d_cache_addr = '0; push_d_main_mem_addr = '0;
    push_copy_count = '0; pop_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Single entry, three copies.
    cycle(1'b1, 0, 16'h1234, 'h10, 'h4, 'h100, 'h20, 3, 1'b1);
    check("lat_valid_n", pop_valid, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1);
      check("r29_cache", pop_cache_addr, 'h10 + 4 * i);
      check("r29_main", pop_main_mem_addr, 'h100 + 'h20 * i);
      check("r29_index", pop_copy_index, i);
    end
    idle(1, 1'b1);
    check("r29_done", pop_valid, 0);

    // Fill past capacity under backpressure, then drain.
    for (int i = 0; i < 17; i++) cycle(1'b1, i & 3, 'hA00 + i, i * 16, 1, 0, 2, 1, 1'b0);
    check("r30_count", count, 16);
    check("r30_full", full, 1);
    check("r30_ovf", overflow, 1);
    idle(20, 1'b1);
    check("r30_full_d", full, 0);
    check("r30_ovf_d", overflow, 1);

    // Backpressure pattern across four copies.
    cycle(1'b1, 2, 16'hBEEF, 'h200, 'h8, 'h300, 'h10, 4, 1'b0);
    idle(1, 1'b0);
    seen.delete();
    for (int i = 0; i < 7; i++) begin
      bit r;
      r = ((7'b1101001 >> i) & 1) != 0;
      if (pop_valid && r) seen.push_back(int'(pop_copy_index));
      idle(1, r);
    end
    check("r31_ntx", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) check("r31_idx", seen[i], i);
    check("r31_done", pop_valid, 0);

    // Address wrap.
    cycle(1'b1, 1, 16'h0042, 'h3FFFE, 'h3, 'h0, 'h0, 2, 1'b1);
    idle(1, 1'b1);
    check("r32_c0", pop_cache_addr, 'h3FFFE);
    idle(1, 1'b1);
    check("r32_c1", pop_cache_addr, 'h00001);
    idle(1, 1'b1);

    // Back-to-back single-copy entries.
    cycle(1'b1, 0, 16'h0AAA, 'h1, 'h0, 'h2, 'h0, 1, 1'b0);
    cycle(1'b1, 3, 16'h0BBB, 'h3, 'h0, 'h4, 'h0, 1, 1'b0);
    check("r33_a_valid", pop_valid, 1);
    check("r33_a_instr", pop_instr, 16'h0AAA);
    idle(1, 1'b1);
    check("r33_b_valid", pop_valid, 1);
    check("r33_b_instr", pop_instr, 16'h0BBB);
    idle(2, 1'b1);

    // Reset while emitting with five entries stored.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1, 'hC00 + i, 'h40, 'h1, 'h80, 'h2, 3, 1'b0);
    idle(1, 1'b1);
    check("r34_pre_valid", pop_valid, 1);
    do_reset();
    idle(6, 1'b1);
    check("r34_post_valid", pop_valid, 0);

    // Random traffic, with one reset midway.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      cycle($urandom_range(0, 99) < 45, $urandom_range(0, 3), $urandom_range(0, 16'hFFFF),
            $urandom_range(0, 18'h3FFFF), $urandom_range(0, 18'h3FFFF),
            $urandom_range(0, 18'h3FFFF), $urandom_range(0, 18'h3FFFF),
            $urandom_range(0, 15), $urandom_range(0, 99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL have parameter LOG_DEPTH, default 4, log2 of the entry count (16 entries).
REQ-002 SHALL have parameter LOG_SUPERSCALAR_WIDTH, default 3, log2 of the max copies per entry (8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port push_we, input, 1, push request from the control unit.
REQ-006 SHALL have port push_instr_type, input, 2, instruction type.
REQ-007 SHALL have port push_instr, input, 16, raw instruction word.
REQ-008 SHALL have ports push_cache_addr, push_main_mem_addr, push_d_cache_addr and push_d_main_mem_addr, input, 18 each: base addresses and per-copy strides.
REQ-009 SHALL have port push_copy_count, input, LOG_SUPERSCALAR_WIDTH+1, copies to emit (1..8).
REQ-010 SHALL have port full, output, 1, high when the entry count equals 2^LOG_DEPTH.
REQ-011 SHALL have port count, output, LOG_DEPTH+1, number of stored entries.
REQ-012 SHALL have port overflow, output, 1, sticky flag indicating a push was dropped.
REQ-013 SHALL have ports pop_valid (output, 1) and pop_ready (input, 1), the downstream valid/ready handshake.
REQ-014 SHALL have ports pop_instr_type (output, 2), pop_instr (output, 16), pop_cache_addr (output, 18), pop_main_mem_addr (output, 18) and pop_copy_index (output, LOG_SUPERSCALAR_WIDTH).

Function
REQ-015 SHALL store entries in a circular FIFO with read/write pointers wrapping modulo 2^LOG_DEPTH.
REQ-016 SHALL accept a push when push_we=1 and full=0 at the clock edge; the entry is stored and count increments.
REQ-017 SHALL drop a push when push_we=1 and full=1, set overflow=1, and leave it set until reset (full sampled before any same-cycle retirement).
REQ-018 SHALL treat push_copy_count=0 as 1 and values above 2^LOG_SUPERSCALAR_WIDTH as 2^LOG_SUPERSCALAR_WIDTH.
REQ-019 SHALL drive all pop_* outputs from registers; the output stage SHALL have two states, IDLE (pop_valid=0) and EMIT (pop_valid=1).
REQ-020 IDLE: if count>0 at the edge, SHALL load the head entry into the output registers with pop_copy_index=0 and go to EMIT; else stay IDLE.
REQ-021 A transfer SHALL occur on an edge where pop_valid=1 and pop_ready=1; with pop_ready=0, all pop_* outputs SHALL hold stable.
REQ-022 On a transfer of a non-last copy, SHALL perform:
  - pop_cache_addr += d_cache_addr (mod 2^18)
  - pop_main_mem_addr += d_main_mem_addr (mod 2^18)
  - pop_copy_index += 1
  - remain in EMIT
  - use accumulation only, no multiplier
REQ-023 On a transfer of the last copy, SHALL retire the head entry (read pointer++, count decrements).
  - If count>=2 at that edge, SHALL load the next entry directly and stay in EMIT (no bubble).
  - Otherwise SHALL go to IDLE.
REQ-024 A push accepted on the same edge as a retirement SHALL leave count unchanged; that pushed entry is not eligible for the direct load of REQ-023.
REQ-025 Latency: a push accepted into an empty queue at edge N SHALL give pop_valid=1 after edge N+1.
REQ-026 Entries SHALL be emitted in push order, and copies in index order 0..copy_count-1.

Reset
REQ-027 While reset=0, asynchronously and regardless of state:
  - pointers, count, overflow, pop_valid, pop_copy_index and all pop_* data SHALL be 0
  - state SHALL be IDLE
  - stored entries are discarded
  - full=0
REQ-028 After reset deasserts, the first push SHALL behave as on an empty queue (REQ-025).

Verification
REQ-029 Single push: type 0, cache 0x10, d_cache 0x4, main 0x100, d_main 0x20, copies 3, pop_ready=1 -> three transfers with cache/main/index = (0x10,0x100,0)(0x14,0x120,1)(0x18,0x140,2), then pop_valid=0.
REQ-030 With pop_ready=0, push 17 entries -> full=1, count=16, 17th dropped, overflow=1; then drain -> the 16 original entries in order, full=0, overflow stays 1.
REQ-031 Backpressure: copies 4, pop_ready pattern 1,0,0,1,0,1,1 -> outputs stable during low cycles, indices 0..3 each delivered exactly once.
REQ-032 Wrap: cache 0x3FFFE, d_cache 0x3, copies 2 -> 0x3FFFE then 0x00001.
REQ-033 Back-to-back: two queued entries with copies 1, pop_ready=1 -> transfers on consecutive edges with no bubble.
REQ-034 Reset asserted mid-EMIT with 5 entries stored -> pop_valid=0, count=0 and overflow=0 immediately; no stale entry emitted after release.
